// File: rtl/encoder_8_3_queued.sv
// Sequential 8:3 priority encoder: latches event pulses into a sticky pending set
// and hands them out one index per valid/ready transfer. Define ENC_ROTATE_EN for round-robin priority.
module encoder_8_3_queued (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic       ready,
    output logic [2:0] Y,
    output logic       valid,
    output logic [7:0] pending,
    output logic       ovf
);

    localparam logic IDLE = 1'b0;
    localparam logic HOLD = 1'b1;

    logic       state;
    logic [2:0] ptr;
    logic [2:0] sel;
    logic       found;
    logic       load;
    logic [7:0] clr;

    // Descending search from ptr, wrapping 0 -> 7; only the registered set is examined.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && pending[ptr - 3'(i)]) begin
                found = 1'b1;
                sel   = ptr - 3'(i);
            end
        end
    end

    assign load  = ((state == IDLE) || ready) && found;
    assign clr   = load ? (8'd1 << sel) : '0;
    assign valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            Y       <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            // A new event on the bit being loaded re-arms it and does not count as overflow.
            pending <= (pending & ~clr) | A;
            if (|(A & pending & ~clr))
                ovf <= 1'b1;
            if (load) begin
                Y     <= sel;
                state <= HOLD;
            end else if ((state == HOLD) && ready) begin
                state <= IDLE;
            end
        end
    end

`ifdef ENC_ROTATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 3'd7;
        else if (load)
            ptr <= sel - 3'd1;
    end
`else
    assign ptr = 3'd7;
`endif

endmodule

// File: doc/encoder_8_3_queued.md
# encoder_8_3_queued

Sequential 8:3 priority encoder: the encode-side counterpart of the team's 3:8 decoder. It captures single-cycle event pulses on eight request lines into a sticky pending set and emits each one as a 3-bit index over a valid/ready handshake, one index per transfer. It sits between raw event sources and any consumer that expects a binary index, for example a downstream 3:8 decoder driving one-hot selects.

## Interface
- No parameters. Widths are fixed at 8 request lines and a 3-bit code.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `A` input 8: event pulses. Bit i high for one cycle marks event i.
- `ready` input 1: consumer accepts `Y` when `valid` and `ready` are both high at a rising edge.
- `Y` output 3: encoded index of the held event.
- `valid` output 1: `Y` holds an unaccepted event.
- `pending` output 8: registered set of captured events not yet loaded into `Y`.
- `ovf` output 1: sticky. Set when an event arrives on a bit that is already pending.

## Operation
- Reset values, applied asynchronously while `rst` is high: `Y`=3'd0, `valid`=0, `pending`=8'h00, `ovf`=0, priority pointer `ptr`=3'd7.
- Two states:
  - IDLE: `valid`=0.
  - HOLD: `valid`=1.
- Load condition (`load`): (IDLE, or HOLD with `ready`) and `pending`≠0.
  - When `load` is true, `Y` takes the selected index k, `valid`=1, and bit k is cleared from `pending`.
- HOLD with `ready` and `pending`=0: go to IDLE. `Y` keeps its last value.
- HOLD without `ready`: `Y` and `valid` hold. `pending` keeps accumulating events.
- Selection reads the registered `pending` only. Events on `A` in the same cycle are never bypassed into `Y`.
- Pending update: `pending_next` = (`pending` & ~clear_k) | `A`.
  - If a new event arrives on bit k in the same cycle that k is loaded, the new event wins and bit k stays set.
- Overflow: `ovf` is set at the edge where `A[i]` & `pending[i]` for any i, unless bit i is being cleared by a load in that same cycle. `ovf` clears only on reset.
- Priority: the search starts at index `ptr` and descends, wrapping from 0 to 7. The first set bit wins.
  - With `ptr` fixed at 7, this is plain MSB-first priority.

## Timing
- Minimum latency: `A[i]` high in cycle 0, then `pending[i]` set at edge 1, then `valid`=1 with `Y`=i at edge 2.
- Throughput: one index per cycle while `ready`=1 and `pending`≠0.
- Back-to-back transfers: on the accepting edge, `valid` stays high and `Y` changes to the next index. There is no bubble.
- Reset asserted mid-transfer: all state is discarded immediately. The first event after `rst` falls follows the minimum-latency rule.
- `A`=0 forever: `valid` stays 0 and `Y` stays constant.

## Configuration
- `ENC_ROTATE_EN` defined: round-robin priority.
  - After loading index k, `ptr` becomes (k−1) mod 8.
  - Example: after granting 0, `ptr`=7.
  - Any continuously re-asserted set of events is served in a fair rotation.
- `ENC_ROTATE_EN` undefined: `ptr` is the constant 7 and the search is fixed MSB-first. Index 7 can starve lower indices.

## Test plan
- Reset, then pulse `A`=8'h04 for one cycle with `ready`=1 → `valid` rises at edge 2 with `Y`=2, then falls one cycle later, and `pending` returns to 8'h00.
- Pulse `A`=8'h91 once with `ready`=1 → `Y` sequence 7, 4, 0 on consecutive cycles with `valid` high for exactly 3 cycles.
- Pulse `A`=8'h01 with `ready`=0 for 5 cycles → `valid`=1 and `Y`=0 held steady. Then pulse `A`=8'h01 again while `pending`=8'h00 → captured with no `ovf`. A third pulse while `pending[0]` is set → `ovf`=1.
- Drive `A`=8'h81 every cycle with `ready`=1:
  - `ENC_ROTATE_EN` defined → `Y` alternates 7, 0, 7, 0.
  - `ENC_ROTATE_EN` undefined → `Y` is always 7 and `pending[0]` never clears.
- Assert `rst` asynchronously in mid-cycle while `valid`=1 and `pending`=8'h3C → all outputs return to their reset values before the next edge.
- Pulse `A`=8'h20 in the same cycle that index 5 is accepted → `pending[5]` remains 1, `ovf` stays 0, and index 5 is emitted a second time.
